// File: rtl/ahb_slave_sram_pkg.sv
// Shared AHB-Lite types plus responder FSM state encoding and lane-enable helper.
package ahb_slave_sram_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } t_htrans;

  typedef enum logic [2:0] {
    HSIZE_BYTE, HSIZE_HALF, HSIZE_WORD, HSIZE_DWORD,
    HSIZE_4WORD, HSIZE_8WORD, HSIZE_16WORD, HSIZE_32WORD
  } t_hsize;

  typedef enum logic [2:0] {
    HBURST_SINGLE, HBURST_INCR, HBURST_WRAP4, HBURST_INCR4,
    HBURST_WRAP8, HBURST_INCR8, HBURST_WRAP16, HBURST_INCR16
  } t_hburst;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } t_hresp;

  typedef logic [2:0] t_slv_state;

  localparam t_slv_state ST_IDLE = 3'd0;
  localparam t_slv_state ST_WAIT = 3'd1;
  localparam t_slv_state ST_DATA = 3'd2;
  localparam t_slv_state ST_ERR1 = 3'd3;
  localparam t_slv_state ST_ERR2 = 3'd4;

  // Little-endian lane enables for up to a 64-bit bus; caller keeps the low DATA_WDT/8 bits.
  function automatic logic [7:0] byte_en(input logic [2:0] addr_lsb, input t_hsize size);
    logic [7:0] mask;
    case (size)
      HSIZE_BYTE:  mask = 8'h01;
      HSIZE_HALF:  mask = 8'h03;
      HSIZE_WORD:  mask = 8'h0f;
      HSIZE_DWORD: mask = 8'hff;
      default:     mask = 8'h00;
    endcase
    return mask << addr_lsb;
  endfunction

endpackage

// File: rtl/ahb_slave_mem.sv
// Word-addressed register-file memory: per-byte write enables, asynchronous read.
module ahb_slave_mem #(
  parameter int unsigned DATA_WDT = 32,
  parameter int unsigned DEPTH    = 256
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [DATA_WDT/8-1:0]      be,
  input  logic [$clog2(DEPTH)-1:0]   addr,
  input  logic [DATA_WDT-1:0]        wdata,
  output logic [DATA_WDT-1:0]        rdata
);

  logic [DATA_WDT-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_WDT / 8; b++) begin
        if (be[b]) begin
          mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_slave_sram.sv
// AHB-Lite SRAM responder with programmable wait states and two-cycle ERROR response.
// Optional write-protect window is built in when AHB_SLAVE_WRITE_PROTECT_EN is defined.
module ahb_slave_sram
  import ahb_slave_sram_pkg::*;
#(
  parameter int unsigned DATA_WDT    = 32,
  parameter int unsigned DEPTH       = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] WP_BASE     = 32'h0,
  parameter logic [31:0] WP_LIMIT    = 32'h0
) (
  input  logic                i_hclk,
  input  logic                i_hreset,
  input  logic                i_hsel,
  input  logic [31:0]         i_haddr,
  input  t_htrans             i_htrans,
  input  t_hsize              i_hsize,
  input  t_hburst             i_hburst,
  input  logic                i_hwrite,
  input  logic [DATA_WDT-1:0] i_hwdata,
  input  logic                i_hready,
  output logic [DATA_WDT-1:0] o_hrdata,
  output logic                o_hready,
  output t_hresp              o_hresp
);

  localparam int unsigned NB        = DATA_WDT / 8;
  localparam int unsigned BW        = $clog2(NB);
  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [31:0] MEM_BYTES = 32'(DEPTH * NB);

  t_slv_state    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q;
  logic [2:0]    lsb_q;
  t_hsize        size_q;
  logic          write_q, valid_q;

  logic [31:0]         offset;
  logic [7:0]          align_mask, be_full;
  logic                range_err, size_err, align_err, wp_err, err;
  logic                can_accept, accept, mem_we;
  logic [DATA_WDT-1:0] mem_rdata;
  logic                unused_hburst, unused_be;

  assign offset     = i_haddr - BASE_ADDR;
  assign align_mask = (8'd1 << i_hsize) - 8'd1;
  assign range_err  = offset >= MEM_BYTES;
  assign size_err   = 32'(i_hsize) > BW;
  assign align_err  = |(i_haddr[7:0] & align_mask);

`ifdef AHB_SLAVE_WRITE_PROTECT_EN
  assign wp_err = i_hwrite && (offset >= WP_BASE) && (offset < WP_LIMIT);
`else
  localparam logic [63:0] unused_wp = {WP_BASE, WP_LIMIT};
  assign wp_err = 1'b0;
`endif

  assign err = range_err | size_err | align_err | wp_err;

  // Only cycles that end a data phase (or idle) can take a new address.
  assign can_accept = (state_q != ST_WAIT) && (state_q != ST_ERR1);
  assign accept     = can_accept && i_hsel && i_hready &&
                      ((i_htrans == HTRANS_NONSEQ) || (i_htrans == HTRANS_SEQ));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ST_DATA;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        if (!accept) begin
          state_d = ST_IDLE;
        end else if (err) begin
          state_d = ST_ERR1;
        end else if (WAIT_STATES == 0) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = 4'(WAIT_STATES);
        end
      end
    endcase
  end

  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      lsb_q   <= '0;
      size_q  <= HSIZE_BYTE;
      write_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (can_accept) begin
        valid_q <= accept & ~err;
        if (accept) begin
          idx_q   <= offset[BW +: AW];
          lsb_q   <= i_haddr[2:0] & 3'(NB - 1);
          size_q  <= i_hsize;
          write_q <= i_hwrite;
        end
      end
    end
  end

  assign be_full       = byte_en(lsb_q, size_q);
  assign unused_be     = ^be_full;
  assign unused_hburst = ^i_hburst;
  assign mem_we        = (state_q == ST_DATA) & valid_q & write_q;

  ahb_slave_mem #(
    .DATA_WDT(DATA_WDT),
    .DEPTH   (DEPTH)
  ) u_mem (
    .clk  (i_hclk),
    .we   (mem_we),
    .be   (be_full[NB-1:0]),
    .addr (idx_q),
    .wdata(i_hwdata),
    .rdata(mem_rdata)
  );

  always_comb begin
    o_hready = can_accept;
    o_hresp  = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    o_hrdata = ((state_q == ST_DATA) && valid_q && !write_q) ? mem_rdata : '0;
  end

endmodule
